// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode pipeline types.
// Holds the {pc, instr} flow bundle and the decode NOP substitute.
package if_id_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_flow_t;

endpackage

// File: rtl/if_id_queue_flow_fifo_mem.sv
// DEPTH x FW register array for the fetch/decode queue.
// One write port, one asynchronous read port; contents are never reset.
module flow_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int FW    = 64,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [FW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [FW-1:0] rdata
);

    logic [FW-1:0] mem [DEPTH];

    // Write the accepted flow into its slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling FIFO with flush; count-based full/empty.
// IF_ID_QUEUE_BYPASS_EN: empty-queue flows pass straight to decode.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [2*WIDTH-1:0]       in_flow,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [2*WIDTH-1:0]       out_flow,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = 2 * WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [FW-1:0] rd_data;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign in_ready = (count != FULL);

    flow_fifo_mem #(
        .DEPTH (DEPTH),
        .FW    (FW),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (in_flow),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Handshake qualification and head presentation
    always_comb begin
        out_valid = !empty;
        out_flow  = empty ? '0 : rd_data;
        push      = in_valid && in_ready;
        pop       = !empty && out_ready;
`ifdef IF_ID_QUEUE_BYPASS_EN
        if (empty && in_valid) begin
            out_valid = 1'b1;
            out_flow  = in_flow;
            push      = !out_ready;
        end
`endif
    end

    // Pointer and occupancy state; flush beats push and pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue.
// Covers fill/drain, streaming wrap, flush, async reset, optional bypass.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic [2*WIDTH-1:0]     in_flow;
    logic                   in_ready;
    logic                   out_valid;
    logic [2*WIDTH-1:0]     out_flow;
    logic                   out_ready;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;

    int checks;
    int failures;

    if_id_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_flow   (in_flow),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flow  (out_flow),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [31:0] pc);
        if_id_flow_t f;
        f.pc    = pc;
        f.instr = pc ^ 32'hDEAD_BEEF;
        return f;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_flow   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_flow", out_flow, 64'd0);
        reset = 1'b1;
        step();

        // 1: fill to full, extra push rejected
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_flow = mk(32'(i * 4));
            step();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_flow = mk(32'h10);
        step();
        chk("full_reject_count", 64'(count), 64'd4);
        chk("full_head", out_flow, mk(32'h0));

        // 2: drain in order
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_%0d", i), out_flow, mk(32'(i * 4)));
            step();
        end
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_out_flow", out_flow, 64'd0);

        // 3: streaming push+pop across pointer wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_flow   = mk(32'h100);
        step();
        out_ready = 1'b1;
        for (int k = 1; k < 10; k++) begin
            in_flow = mk(32'(32'h100 + 4 * k));
            chk($sformatf("stream_%0d", k - 1), out_flow,
                mk(32'(32'h100 + 4 * (k - 1))));
            chk($sformatf("stream_cnt_%0d", k), 64'(count), 64'd1);
            step();
        end
        in_valid = 1'b0;
        chk("stream_last", out_flow, mk(32'h124));
        step();
        chk("stream_empty", 64'(count), 64'd0);

        // 4: flush beats a same-cycle push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_flow = mk(32'(32'h180 + 4 * i));
            step();
        end
        chk("pre_flush_count", 64'(count), 64'd3);
        flush   = 1'b1;
        in_flow = mk(32'h200);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_flow  = mk(32'h300);
        step();
        in_valid = 1'b0;
        chk("post_flush_head", out_flow, mk(32'h300));
        chk("post_flush_count", 64'(count), 64'd1);

        // 5: asynchronous reset mid-cycle
        in_valid = 1'b1;
        in_flow  = mk(32'h304);
        step();
        in_valid = 1'b0;
        chk("pre_reset_count", 64'(count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        #1;
        reset = 1'b1;
        step();

`ifdef IF_ID_QUEUE_BYPASS_EN
        // 6: zero-latency bypass when empty
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_flow   = mk(32'h40);
        #1;
        chk("byp_out_valid", 64'(out_valid), 64'd1);
        chk("byp_out_flow", out_flow, mk(32'h40));
        step();
        chk("byp_count", 64'(count), 64'd0);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("byp_store_count", 64'(count), 64'd1);
        chk("byp_store_head", out_flow, mk(32'h40));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Decoupling buffer between the fetch stage and the decode stage. It holds fetched {pc, instr} flows in a small FIFO, so a decode stall no longer forces fetch to stall in the same cycle. A taken redirect (flush) discards all wrong-path entries. Upstream it consumes the fetch stage's outflow; downstream it drives the decode stage's inflow using a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- WIDTH, 32, width of pc and instr.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  the fetch stage presents a flow.
- in_flow  input  2*WIDTH  if_id_flow_t {pc, instr} from fetch.
- in_ready  output  1  the queue accepts in_flow this cycle.
- out_valid  output  1  out_flow holds a valid flow for decode.
- out_flow  output  2*WIDTH  if_id_flow_t at the queue head.
- out_ready  input  1  decode consumes out_flow this cycle.
- flush  input  1  redirect taken; discard all contents.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, in_ready=1, out_flow=0.
  - Storage contents are not reset.
- Push: in_valid && in_ready at a clock edge writes in_flow to mem[wr_ptr]; wr_ptr increments, wrapping modulo DEPTH.
- Pop: out_valid && out_ready at a clock edge increments rd_ptr, wrapping modulo DEPTH.
- Flow control:
  - in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready; a full queue does not accept a push in the same cycle as a pop.
  - out_valid = (count != 0).
  - out_flow = mem[rd_ptr] when count != 0, otherwise all zeros.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Latency: a flow pushed at edge N appears on out_flow after edge N, so decode sees it one cycle later. Entries leave in strict FIFO order.
- Flush has priority over push and pop:
  - At the edge with flush=1: rd_ptr=wr_ptr=0, count=0.
  - A push in the same cycle is discarded; a pop in the same cycle is ignored.
  - in_ready remains as computed; the fetch stage must treat a flush cycle as a redirect.
  - During the flush cycle out_valid still reflects the pre-flush state. Decode must gate it with flush.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, never from pointer equality.
- Reset asserted mid-transfer: all contents are lost immediately; there is no partial write.
- Stall mapping: the fetch stage asserts its PC stall whenever !in_ready.

Optional Feature:
IF_ID_QUEUE_BYPASS_EN
- Defined:
  - When count==0 and in_valid=1: out_valid=1 and out_flow=in_flow combinationally.
  - If out_ready=1 in that cycle, the flow is consumed directly and nothing is written; count stays 0.
  - If out_ready=0, the flow is written normally.
  - A flush in that cycle still wins: nothing is stored.
  - This gives zero-cycle latency when the queue is empty.
- Not defined: no combinational path from in_* to out_*; latency is always at least 1 cycle as above.

Decomposition:
- Shared pipeline package: if_id_flow_t (struct {pc, instr}, WIDTH each) and a NOP_INSTR constant (32'h00000013).
- Decode uses NOP_INSTR to substitute the instruction when out_valid=0.
- Pointer/count logic stays inline.
- One natural sub-module: flow_fifo_mem, a DEPTH x 2*WIDTH register array with one write port and one asynchronous read port.

Test Plan:
1. Reset, then push pc=0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0. A further push of pc=0x10 is rejected and count stays 4.
2. From the full state of test 1, set out_ready=1 and in_valid=0 -> out_flow.pc is 0x0, 0x4, 0x8, 0xC on successive cycles; then out_valid=0 and count=0.
3. Continuous push and pop for 10 cycles with pc incrementing by 4 from 0x100 -> count is constant at 1 after the first edge. Outputs are 0x100..0x124 in order, with correct pointer wrap past DEPTH.
4. Load 3 entries, then assert flush together with in_valid (pc=0x200) -> after the edge count=0, out_valid=0. The next push of pc=0x300 is the next output.
5. Assert reset low asynchronously mid-cycle with count=2 -> out_valid drops immediately without a clock edge; count=0.
6. With IF_ID_QUEUE_BYPASS_EN defined, empty queue, in_valid=1 with pc=0x40 and out_ready=1 -> out_flow.pc=0x40 in the same cycle, count remains 0. Repeat with out_ready=0 -> count=1.
